// File: rtl/scg_self_ref_seq_if.sv
// ----------------------------------------------------------------------------
// scg_self_ref_seq_if
// Handshake/command bundle between the command arbiter (master) and the
// self-refresh sequencer (slave).
//   start       master->slave  self-refresh request, level, held while wanted
//   command     slave->master  SDRAM command {cs_n,ras_n,cas_n,we_n}
//   cke         slave->master  SDRAM clock enable
//   in_self_ref slave->master  device held in self-refresh
//   busy        slave->master  sequencer owns the command bus
//   exit_done   slave->master  one-cycle pulse, device usable again
// ----------------------------------------------------------------------------
interface scg_self_ref_seq_if;
   logic       start;
   logic [3:0] command;
   logic       cke;
   logic       in_self_ref;
   logic       busy;
   logic       exit_done;

   modport master (
      output start,
      input  command, cke, in_self_ref, busy, exit_done
   );

   modport slave (
      input  start,
      output command, cke, in_self_ref, busy, exit_done
   );
endinterface

// File: rtl/scg_self_ref_seq.sv
// ----------------------------------------------------------------------------
// scg_self_ref_seq
// Self-refresh entry/exit sequencer for the SDRAM command generator.
// Entry: PRECHARGE ALL, wait tRP, SELF REFRESH with CKE low, hold for at
// least TCKE_MIN cycles. Exit: raise CKE, issue NOPs for tXSR, pulse
// exit_done and hand the bus back.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   sr     slave side of scg_self_ref_seq_if (start in; command, cke,
//          in_self_ref, busy, exit_done out)
// All outputs are registered and decoded from the state only, so start has
// no combinational path to any output.
// ----------------------------------------------------------------------------
module scg_self_ref_seq #(
   parameter int TRP_CYC  = 3,
   parameter int TCKE_MIN = 4,
   parameter int TXSR_CYC = 10,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               n_rst,
   scg_self_ref_seq_if.slave  sr
);

   localparam longint CNT_SPAN = 64'd1 << CNT_W;

   generate
      if (TRP_CYC < 1 || TCKE_MIN < 1 || TXSR_CYC < 1) begin : g_bad_range
         $error("scg_self_ref_seq: timing parameters must be 1 or more");
      end
      if (longint'(TRP_CYC) > CNT_SPAN || longint'(TCKE_MIN) > CNT_SPAN ||
          longint'(TXSR_CYC) > CNT_SPAN) begin : g_bad_width
         $error("scg_self_ref_seq: timing parameter exceeds 2**CNT_W");
      end
   endgenerate

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PALL = 4'b0010;
   localparam logic [3:0] CMD_SREF = 4'b0001;

   // PRECHARGE itself counts as one tRP cycle, so WAIT_RP lasts TRP_CYC-1.
   localparam bit              HAS_WAIT_RP = (TRP_CYC >= 2);
   localparam logic [CNT_W-1:0] LD_RP   = CNT_W'((TRP_CYC >= 2) ? TRP_CYC - 2 : 0);
   localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(TCKE_MIN - 1);
   localparam logic [CNT_W-1:0] LD_XSR  = CNT_W'(TXSR_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_WAIT_RP,
      S_ENTER,
      S_HOLD,
      S_EXIT,
      S_DONE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             start;

   logic [3:0] command_q;
   logic       cke_q;
   logic       in_self_ref_q;
   logic       busy_q;
   logic       exit_done_q;

   assign start = sr.start;

   // next state / counter
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (start) state_n = S_PRE;
         end
         S_PRE: begin
            if (HAS_WAIT_RP) begin
               state_n = S_WAIT_RP;
               cnt_n   = LD_RP;
            end else begin
               state_n = S_ENTER;
            end
         end
         S_WAIT_RP: begin
            if (cnt == '0) state_n = S_ENTER;
            else           cnt_n   = cnt - 1'b1;
         end
         S_ENTER: begin
            state_n = S_HOLD;
            cnt_n   = LD_HOLD;
         end
         S_HOLD: begin
            // count runs down regardless of start and then parks at zero;
            // exit needs both residency served and the request withdrawn
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else if (!start) begin
               state_n = S_EXIT;
               cnt_n   = LD_XSR;
            end
         end
         S_EXIT: begin
            if (cnt == '0) state_n = S_DONE;
            else           cnt_n   = cnt - 1'b1;
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // state, counter and outputs; outputs are decoded from the state being
   // entered so they line up with the state register cycle for cycle
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         command_q     <= CMD_NOP;
         cke_q         <= 1'b1;
         in_self_ref_q <= 1'b0;
         busy_q        <= 1'b0;
         exit_done_q   <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         command_q     <= CMD_NOP;
         cke_q         <= 1'b1;
         in_self_ref_q <= 1'b0;
         busy_q        <= (state_n != S_IDLE);
         exit_done_q   <= 1'b0;
         case (state_n)
            S_PRE:   command_q <= CMD_PALL;
            S_ENTER: begin
               command_q <= CMD_SREF;
               cke_q     <= 1'b0;
            end
            S_HOLD: begin
               cke_q         <= 1'b0;
               in_self_ref_q <= 1'b1;
            end
            S_DONE:  exit_done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign sr.command     = command_q;
   assign sr.cke         = cke_q;
   assign sr.in_self_ref = in_self_ref_q;
   assign sr.busy        = busy_q;
   assign sr.exit_done   = exit_done_q;

endmodule

// File: tb/tb_scg_self_ref_seq.sv
// ----------------------------------------------------------------------------
// tb_scg_self_ref_seq
// Directed bench for the self-refresh sequencer: one instance with default
// timing, one with all timings at 1. Cycle c is the interval after the c-th
// clock edge counted from the cycle in which start is first driven.
// Output vector compared per cycle: {command, cke, in_self_ref, busy, exit_done}.
// ----------------------------------------------------------------------------
module tb_scg_self_ref_seq;

   localparam logic [3:0] NOP  = 4'b0111;
   localparam logic [3:0] PALL = 4'b0010;
   localparam logic [3:0] SREF = 4'b0001;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   scg_self_ref_seq_if sif ();
   scg_self_ref_seq_if tif ();

   scg_self_ref_seq u_dut (
      .clk   (clk),
      .n_rst (n_rst),
      .sr    (sif)
   );

   scg_self_ref_seq #(
      .TRP_CYC  (1),
      .TCKE_MIN (1),
      .TXSR_CYC (1),
      .CNT_W    (4)
   ) u_dut_min (
      .clk   (clk),
      .n_rst (n_rst),
      .sr    (tif)
   );

   wire [7:0] dv = {sif.command, sif.cke, sif.in_self_ref, sif.busy, sif.exit_done};
   wire [7:0] tv = {tif.command, tif.cke, tif.in_self_ref, tif.busy, tif.exit_done};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sif.start = 1'b0;
      tif.start = 1'b0;
      n_rst     = 1'b0;
      #12;
      checks++;
      if (dv !== {NOP, 4'b1000}) begin
         errors++;
         $display("FAIL reset_default: got %b want %b", dv, {NOP, 4'b1000});
      end
      checks++;
      if (tv !== {NOP, 4'b1000}) begin
         errors++;
         $display("FAIL reset_min: got %b want %b", tv, {NOP, 4'b1000});
      end
      tick();
      n_rst = 1'b1;
      tick();
      tick();
      checks++;
      if (dv !== {NOP, 4'b1000}) begin
         errors++;
         $display("FAIL reset_idle_after_release: got %b want %b", dv, {NOP, 4'b1000});
      end
   endtask

   // single-cycle start pulse, default timing
   task automatic test_min_pulse();
      logic [7:0] e;
      sif.start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) sif.start = 1'b0;
         e = {(c == 1) ? PALL : (c == 4) ? SREF : NOP,
              !(c >= 4 && c <= 8), (c >= 5 && c <= 8), (c <= 19), (c == 19)};
         checks++;
         if (dv !== e) begin
            errors++;
            $display("FAIL min_pulse cycle %0d: got %b want %b", c, dv, e);
         end
      end
   endtask

   // start held for cycles 0..49
   task automatic test_long_hold();
      logic [7:0] e;
      sif.start = 1'b1;
      for (int c = 1; c <= 62; c++) begin
         tick();
         if (c == 50) sif.start = 1'b0;
         e = {(c == 1) ? PALL : (c == 4) ? SREF : NOP,
              !(c >= 4 && c <= 50), (c >= 5 && c <= 50), (c <= 61), (c == 61)};
         checks++;
         if (dv !== e) begin
            errors++;
            $display("FAIL long_hold cycle %0d: got %b want %b", c, dv, e);
         end
      end
   endtask

   // all timings 1: PALL, SREF, HOLD, EXIT, DONE back to back
   task automatic test_min_timing();
      logic [7:0] e;
      tif.start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) tif.start = 1'b0;
         e = {(c == 1) ? PALL : (c == 2) ? SREF : NOP,
              !(c == 2 || c == 3), (c == 3), (c <= 5), (c == 5)};
         checks++;
         if (tv !== e) begin
            errors++;
            $display("FAIL min_timing cycle %0d: got %b want %b", c, tv, e);
         end
      end
   endtask

   // start re-raised at cycle 12 (inside EXIT), dropped again at cycle 24
   task automatic test_back_to_back();
      logic [7:0] e;
      sif.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c == 1)  sif.start = 1'b0;
         if (c == 12) sif.start = 1'b1;
         if (c == 24) sif.start = 1'b0;
         e = {(c == 1 || c == 21) ? PALL : (c == 4 || c == 24) ? SREF : NOP,
              !((c >= 4 && c <= 8) || (c >= 24 && c <= 28)),
              (c >= 5 && c <= 8) || (c >= 25 && c <= 28),
              (c <= 19) || (c >= 21 && c <= 39),
              (c == 19 || c == 39)};
         checks++;
         if (dv !== e) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: got %b want %b", c, dv, e);
         end
      end
   endtask

   // asynchronous reset while in HOLD
   task automatic test_reset_in_hold();
      sif.start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) sif.start = 1'b0;
      end
      checks++;
      if (sif.in_self_ref !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_hold precondition in_self_ref: got %b want 1", sif.in_self_ref);
      end
      #3;
      n_rst = 1'b0;
      #1;
      checks++;
      if (dv !== {NOP, 4'b1000}) begin
         errors++;
         $display("FAIL reset_in_hold async: got %b want %b", dv, {NOP, 4'b1000});
      end
      tick();
      tick();
      n_rst = 1'b1;
      for (int c = 0; c < 25; c++) begin
         tick();
         checks++;
         if (sif.exit_done !== 1'b0 || sif.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_hold after %0d: exit_done=%b busy=%b want 0 0",
                     c, sif.exit_done, sif.busy);
         end
      end
   endtask

   // random start toggling with protocol monitors
   task automatic test_random();
      int   last_pall = -1000;
      int   rise      = -1000;
      int   ndone     = 0;
      logic prev_cke  = 1'b1;
      int   waited;
      sif.start = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if ($urandom_range(0, 15) == 0) sif.start = ~sif.start;
         tick();
         checks++;
         if ((sif.cke == 1'b0) !== (sif.command == SREF || sif.in_self_ref == 1'b1)) begin
            errors++;
            $display("FAIL random cke_window cycle %0d: cke=%b cmd=%b in_self_ref=%b",
                     cyc, sif.cke, sif.command, sif.in_self_ref);
         end
         if (sif.command == PALL) last_pall = cyc;
         if (cyc - last_pall == 3) begin
            checks++;
            if (sif.command !== SREF) begin
               errors++;
               $display("FAIL random pall_to_sref cycle %0d: got cmd %b want %b", cyc, sif.command, SREF);
            end
         end
         if (sif.command == SREF) begin
            checks++;
            if (cyc - last_pall != 3) begin
               errors++;
               $display("FAIL random sref_gap cycle %0d: got %0d want 3", cyc, cyc - last_pall);
            end
         end
         if (prev_cke == 1'b0 && sif.cke == 1'b1) rise = cyc;
         if (sif.exit_done) begin
            ndone++;
            checks++;
            if (cyc - rise != 10) begin
               errors++;
               $display("FAIL random txsr cycle %0d: got %0d want 10", cyc, cyc - rise);
            end
         end
         prev_cke = sif.cke;
      end
      sif.start = 1'b0;
      waited = 0;
      while (sif.busy && waited < 200) begin
         tick();
         waited++;
      end
      checks++;
      if (sif.busy !== 1'b0) begin
         errors++;
         $display("FAIL random drain: busy=%b want 0 within 200 cycles", sif.busy);
      end
      checks++;
      if (ndone < 1) begin
         errors++;
         $display("FAIL random activity: exit_done count %0d want at least 1", ndone);
      end
   endtask

   initial begin
      test_reset();
      test_min_pulse();
      tick();
      test_long_hold();
      tick();
      test_min_timing();
      tick();
      test_back_to_back();
      tick();
      test_reset_in_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
